dma_out_engine: RTL and testbench

- Downstream consumer of the CPU top's DMA outputs (memAddr, memDataOut, en).
- Buffers CPU-issued write words in a small FIFO and replays them one at a time on the host-side DMA bus using a req/ack handshake.
- Applies back-pressure to the CPU when full.
- Reports drain-complete after CPU halt, so the host can read results once every pending write has landed.

---
 rtl/dma_out_engine_if.sv | 30 +++
 rtl/dma_out_engine.sv | 194 +++++++++++++++++++
 tb/tb_dma_out_engine.sv | 362 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dma_out_engine_if.sv
`default_nettype none
// ============================================================================
//  Module   : dma_out_engine_if
//  Purpose  : Host-side DMA request/acknowledge bus. The engine drives the
//             request, address and data; the host returns the acknowledge.
//  Revision : 1.0 - initial release
// ============================================================================
interface dma_out_engine_if;
    logic        bus_req;
    logic [31:0] bus_addr;
    logic [31:0] bus_data;
    logic        bus_ack;

    // Engine side: issues requests and holds them until acknowledged
    modport master (
        output bus_req,
        output bus_addr,
        output bus_data,
        input  bus_ack
    );

    // Host side: observes requests and acknowledges them
    modport slave (
        input  bus_req,
        input  bus_addr,
        input  bus_data,
        output bus_ack
    );
endinterface
`default_nettype wire

// File: rtl/dma_out_engine.sv
`default_nettype none
// ============================================================================
//  Module   : dma_out_engine
//  Purpose  : Buffers CPU write words in a small FIFO and replays them in
//             order on the host DMA bus with a req/ack handshake. Back-pressures
//             the CPU when full and flags drain-complete after CPU halt.
//  Options  : define DMA_TIMEOUT_EN to abandon a request after TIMEOUT cycles
//             without acknowledge (sets sticky timeout_err).
//  Revision : 1.0 - initial release
// ============================================================================
module dma_out_engine #(
    parameter int DEPTH   = 4,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_en,
    input  logic [31:0]       cpu_addr,
    input  logic [31:0]       cpu_data,
    input  logic              cpu_halt,
    output logic              cpu_full,
    dma_out_engine_if.master  bus,
    output logic              drained,
    output logic              overflow,
    output logic [CNT_W-1:0]  xfer_cnt,
    output logic              timeout_err
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_OCC_W = $clog2(DEPTH + 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_t;

    state_t             r_state;
    logic [31:0]        r_mem_addr [DEPTH];
    logic [31:0]        r_mem_data [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_OCC_W-1:0] r_count;

    logic               r_bus_req;
    logic [31:0]        r_bus_addr;
    logic [31:0]        r_bus_data;
    logic [CNT_W-1:0]   r_xfer_cnt;
    logic               r_overflow;
    logic               r_halt_seen;
    logic               r_drained;

    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic               w_adv;
    logic               w_timeout;

    assign w_empty  = (r_count == '0);
    assign cpu_full = (r_count == c_OCC_W'(DEPTH));
    // A full FIFO refuses the word even if a pop frees a slot this cycle
    assign w_push   = cpu_en && !cpu_full;
    // The current request retires on acknowledge or on abandonment
    assign w_adv    = (r_state == ST_REQ) && (bus.bus_ack || w_timeout);
    assign w_pop    = !w_empty && ((r_state == ST_IDLE) || w_adv);

    assign bus.bus_req  = r_bus_req;
    assign bus.bus_addr = r_bus_addr;
    assign bus.bus_data = r_bus_data;
    assign xfer_cnt     = r_xfer_cnt;
    assign overflow     = r_overflow;
    assign drained      = r_drained;

`ifdef DMA_TIMEOUT_EN
    localparam int c_TO_W = $clog2(TIMEOUT + 1);

    logic [c_TO_W-1:0] r_wait_cnt;
    logic              r_timeout_err;

    // The last waiting cycle without acknowledge abandons the word
    assign w_timeout   = (r_state == ST_REQ) && !bus.bus_ack &&
                         (r_wait_cnt == c_TO_W'(TIMEOUT - 1));
    assign timeout_err = r_timeout_err;

    // Count cycles spent waiting on the presented word; restart on every load
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wait_cnt    <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (w_timeout) begin
                r_timeout_err <= 1'b1;
            end
            if ((r_state == ST_IDLE) || w_adv) begin
                r_wait_cnt <= '0;
            end else begin
                r_wait_cnt <= r_wait_cnt + c_TO_W'(1);
            end
        end
    end
`else
    // Requests wait forever in this build, so the error can never assert
    assign w_timeout   = 1'b0;
    assign timeout_err = (TIMEOUT < 0);
`endif

    // FIFO storage: written on accepted pushes only, no reset needed
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_addr[r_wr_ptr] <= cpu_addr;
            r_mem_data[r_wr_ptr] <= cpu_data;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_OCC_W'(1);
                2'b01:   r_count <= r_count - c_OCC_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Status flags: sticky overflow and halt, registered drain-complete
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_overflow  <= 1'b0;
            r_halt_seen <= 1'b0;
            r_drained   <= 1'b0;
        end else begin
            if (cpu_en && cpu_full) begin
                r_overflow <= 1'b1;
            end
            if (cpu_halt) begin
                r_halt_seen <= 1'b1;
            end
            r_drained <= r_halt_seen && w_empty && (r_state == ST_IDLE);
        end
    end

    // Bus FSM: load the FIFO head, hold it until retired, chain back-to-back
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_bus_req  <= 1'b0;
            r_bus_addr <= '0;
            r_bus_data <= '0;
            r_xfer_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        r_bus_addr <= r_mem_addr[r_rd_ptr];
                        r_bus_data <= r_mem_data[r_rd_ptr];
                        r_bus_req  <= 1'b1;
                        r_state    <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (bus.bus_ack) begin
                        r_xfer_cnt <= r_xfer_cnt + CNT_W'(1);
                    end
                    if (w_adv) begin
                        if (!w_empty) begin
                            r_bus_addr <= r_mem_addr[r_rd_ptr];
                            r_bus_data <= r_mem_data[r_rd_ptr];
                        end else begin
                            r_bus_req <= 1'b0;
                            r_state   <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_bus_req <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dma_out_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dma_out_engine
//  Purpose  : Self-checking bench for dma_out_engine: vector table, directed
//             corner-case sequences and randomized traffic against a
//             queue-based reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dma_out_engine;

    localparam int c_DEPTH = 4;
    localparam int c_CNT_W = 4;
`ifdef DMA_TIMEOUT_EN
    localparam int c_TO    = 8;
`else
    localparam int c_TO    = 255;
`endif

    logic              clk;
    logic              rst_n;
    logic              cpu_en;
    logic [31:0]       cpu_addr;
    logic [31:0]       cpu_data;
    logic              cpu_halt;
    logic              cpu_full;
    logic              drained;
    logic              overflow;
    logic [c_CNT_W-1:0] xfer_cnt;
    logic              timeout_err;

    dma_out_engine_if bus_if ();

    dma_out_engine #(
        .DEPTH   (c_DEPTH),
        .CNT_W   (c_CNT_W),
        .TIMEOUT (c_TO)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cpu_en      (cpu_en),
        .cpu_addr    (cpu_addr),
        .cpu_data    (cpu_data),
        .cpu_halt    (cpu_halt),
        .cpu_full    (cpu_full),
        .bus         (bus_if),
        .drained     (drained),
        .overflow    (overflow),
        .xfer_cnt    (xfer_cnt),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock edge, outputs sampled 1 time unit later
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        cpu_en         = 1'b0;
        cpu_halt       = 1'b0;
        cpu_addr       = '0;
        cpu_data       = '0;
        bus_if.bus_ack = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic               rst_n;
        logic               en;
        logic [31:0]        addr;
        logic [31:0]        data;
        logic               ack;
        logic               e_req;
        logic [31:0]        e_addr;
        logic [31:0]        e_data;
        logic               e_full;
        logic               e_ovf;
        logic [c_CNT_W-1:0] e_cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic en, logic [31:0] a, logic [31:0] d, logic ack,
                                logic er, logic [31:0] ea, logic [31:0] ed,
                                logic ef, logic eo, logic [c_CNT_W-1:0] ec);
        vec_t v;
        v.rst_n = r;  v.en = en;  v.addr = a;  v.data = d;  v.ack = ack;
        v.e_req = er; v.e_addr = ea; v.e_data = ed;
        v.e_full = ef; v.e_ovf = eo; v.e_cnt = ec;
        return v;
    endfunction

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } word_t;

    word_t m_q[$];
    word_t m_cur;
    bit    m_busy, m_ovf, m_halt, m_drained, m_terr;
    int    m_cnt, m_wait;

    task automatic model_reset();
        m_q.delete();
        m_cur = '0; m_busy = 0; m_ovf = 0; m_halt = 0; m_drained = 0; m_terr = 0;
        m_cnt = 0;  m_wait = 0;
    endtask

    // Advance the model by one clock edge using the inputs present before it
    task automatic model_edge(input bit en, input word_t w, input bit ack, input bit halt);
        bit full;
        bit nd;
        bit adv;
        full = (m_q.size() == c_DEPTH);
        nd   = m_halt && (m_q.size() == 0) && !m_busy;
        if (en && full) m_ovf = 1;
        if (halt) m_halt = 1;
        if (!m_busy) begin
            if (m_q.size() > 0) begin
                m_cur  = m_q.pop_front();
                m_busy = 1;
                m_wait = 0;
            end
        end else begin
            adv = ack;
            if (ack) begin
                m_cnt = (m_cnt + 1) % (1 << c_CNT_W);
            end
`ifdef DMA_TIMEOUT_EN
            else begin
                m_wait++;
                if (m_wait == c_TO) begin
                    adv    = 1;
                    m_terr = 1;
                end
            end
`endif
            if (adv) begin
                m_wait = 0;
                if (m_q.size() > 0) m_cur = m_q.pop_front();
                else                m_busy = 0;
            end
        end
        if (en && !full) m_q.push_back(w);
        m_drained = nd;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        vec_t  v;
        word_t w;
        int    n;
        bit    en_r, ack_r, halt_r;

        do_reset();
        chk("rst_req",     bus_if.bus_req, 0);
        chk("rst_addr",    bus_if.bus_addr, 0);
        chk("rst_data",    bus_if.bus_data, 0);
        chk("rst_full",    cpu_full, 0);
        chk("rst_drained", drained, 0);
        chk("rst_ovf",     overflow, 0);
        chk("rst_cnt",     xfer_cnt, 0);
        chk("rst_terr",    timeout_err, 0);

        // Single write, held request, then acknowledge
        vecs.push_back(mk(1, 1, 32'h100, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(1, 0, 0, 0, 0, 1, 32'h100, 32'hDEADBEEF, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // Burst of six with no acknowledge: fill, then overflow
        vecs.push_back(mk(1, 1, 32'h200, 32'hA0000000, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 1; i < 6; i++)
            vecs.push_back(mk(1, 1, 32'h200 + 4 * i, 32'hA0000000 + i, 0,
                              1, 32'h200, 32'hA0000000, (i >= 4), (i == 5), 0));
        for (int i = 1; i < 5; i++)
            vecs.push_back(mk(1, 0, 0, 0, 1, 1, 32'h200 + 4 * i, 32'hA0000000 + i, 0, 1, c_CNT_W'(i)));
        vecs.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 1, 5));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // Continuous acknowledge with a push every cycle
        vecs.push_back(mk(1, 1, 32'h300, 32'hC0DE0000, 1, 0, 0, 0, 0, 0, 0));
        for (int k = 2; k <= 10; k++)
            vecs.push_back(mk(1, 1, 32'h300 + 4 * (k - 1), 32'hC0DE0000 + k - 1, 1,
                              1, 32'h300 + 4 * (k - 2), 32'hC0DE0000 + k - 2, 0, 0, c_CNT_W'(k - 2)));
        vecs.push_back(mk(1, 0, 0, 0, 1, 1, 32'h300 + 4 * 9, 32'hC0DE0009, 0, 0, 9));
        vecs.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 10));

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            rst_n = v.rst_n; cpu_en = v.en; cpu_addr = v.addr; cpu_data = v.data;
            bus_if.bus_ack = v.ack;
            step();
            chk($sformatf("vec%0d_req", i), bus_if.bus_req, v.e_req);
            if (v.e_req) begin
                chk($sformatf("vec%0d_addr", i), bus_if.bus_addr, v.e_addr);
                chk($sformatf("vec%0d_data", i), bus_if.bus_data, v.e_data);
            end
            chk($sformatf("vec%0d_full", i), cpu_full, v.e_full);
            chk($sformatf("vec%0d_ovf", i), overflow, v.e_ovf);
            chk($sformatf("vec%0d_cnt", i), xfer_cnt, v.e_cnt);
        end
        rst_n = 1; cpu_en = 0; bus_if.bus_ack = 0;

        // Drain: three words, halt pulse, each acked after two wait cycles
        do_reset();
        for (int i = 0; i < 3; i++) begin
            cpu_en = 1; cpu_addr = 32'h400 + i; cpu_data = 32'hD0 + i;
            step();
        end
        cpu_en = 0; cpu_halt = 1;
        step();
        cpu_halt = 0;
        for (int i = 0; i < 3; i++) begin
            n = 0;
            while (!bus_if.bus_req && n < 20) begin step(); n++; end
            chk("drain_req_seen", bus_if.bus_req, 1);
            chk("drain_addr", bus_if.bus_addr, 32'h400 + i);
            step(); step();
            chk("drain_wait_drained", drained, 0);
            bus_if.bus_ack = 1;
            step();
            bus_if.bus_ack = 0;
            chk("drain_ack_drained", drained, 0);
        end
        chk("drain_cnt", xfer_cnt, 3);
        chk("drain_req_low", bus_if.bus_req, 0);
        step();
        chk("drain_set", drained, 1);
        step();
        chk("drain_sticky", drained, 1);
        cpu_en = 1; cpu_addr = 32'h500; cpu_data = 32'h55;
        step();
        cpu_en = 0;
        chk("drain_after_push", drained, 1);
        step();
        chk("drain_cleared", drained, 0);
        bus_if.bus_ack = 1;
        step();
        bus_if.bus_ack = 0;
        step();
        chk("drain_reset", drained, 1);

        // Reset while words are pending
        do_reset();
        for (int i = 0; i < 3; i++) begin
            cpu_en = 1; cpu_addr = 32'h600 + i; cpu_data = i;
            step();
        end
        cpu_en = 0;
        chk("mid_req_before", bus_if.bus_req, 1);
        rst_n = 0;
        step();
        rst_n = 1;
        chk("mid_req", bus_if.bus_req, 0);
        chk("mid_full", cpu_full, 0);
        chk("mid_cnt", xfer_cnt, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("mid_quiet", bus_if.bus_req, 0);
        end

        // Unacknowledged first word
        do_reset();
        cpu_en = 1; cpu_addr = 32'h700; cpu_data = 32'h70;
        step();
        cpu_addr = 32'h704; cpu_data = 32'h71;
        step();
        cpu_en = 0;
`ifdef DMA_TIMEOUT_EN
        for (int i = 0; i < 7; i++) step();
        chk("to_hold_addr", bus_if.bus_addr, 32'h700);
        chk("to_hold_err", timeout_err, 0);
        step();
        chk("to_next_req", bus_if.bus_req, 1);
        chk("to_next_addr", bus_if.bus_addr, 32'h704);
        chk("to_err", timeout_err, 1);
        chk("to_cnt0", xfer_cnt, 0);
        bus_if.bus_ack = 1;
        step();
        bus_if.bus_ack = 0;
        chk("to_req_low", bus_if.bus_req, 0);
        chk("to_cnt1", xfer_cnt, 1);
`else
        for (int i = 0; i < 20; i++) step();
        chk("wait_req", bus_if.bus_req, 1);
        chk("wait_addr", bus_if.bus_addr, 32'h700);
        chk("wait_err", timeout_err, 0);
        bus_if.bus_ack = 1;
        step();
        chk("wait_next_addr", bus_if.bus_addr, 32'h704);
        chk("wait_cnt1", xfer_cnt, 1);
        step();
        bus_if.bus_ack = 0;
        chk("wait_req_low", bus_if.bus_req, 0);
        chk("wait_cnt2", xfer_cnt, 2);
`endif

        // Randomized traffic against the reference model
        do_reset();
        model_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            en_r = ($urandom_range(2, 0) != 0);
            if (cpu_full && ($urandom_range(7, 0) != 0)) en_r = 0;
            if (cyc >= 2800) en_r = 0;
            case ((cyc / 500) % 3)
                0:       ack_r = ($urandom_range(3, 0) == 0);
                1:       ack_r = ($urandom_range(1, 0) == 0);
                default: ack_r = ($urandom_range(7, 0) != 0);
            endcase
            halt_r = (cyc == 1700);
            w.a = $urandom();
            w.d = $urandom();
            cpu_en = en_r; cpu_addr = w.a; cpu_data = w.d;
            bus_if.bus_ack = ack_r; cpu_halt = halt_r;
            model_edge(en_r, w, ack_r, halt_r);
            step();
            chk("rnd_req", bus_if.bus_req, m_busy);
            if (m_busy) begin
                chk("rnd_addr", bus_if.bus_addr, m_cur.a);
                chk("rnd_data", bus_if.bus_data, m_cur.d);
            end
            chk("rnd_full", cpu_full, (m_q.size() == c_DEPTH));
            chk("rnd_cnt", xfer_cnt, m_cnt);
            chk("rnd_ovf", overflow, m_ovf);
            chk("rnd_drained", drained, m_drained);
            chk("rnd_terr", timeout_err, m_terr);
        end
        cpu_en = 0; bus_if.bus_ack = 0; cpu_halt = 0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
